soc_system_pio_in_capture: RTL and testbench
============================================

# soc_system_pio_in_capture

Parametrised Avalon-MM input port for the HPS/FPGA `soc_system`: samples a `WIDTH`-bit external status bus (FIFO flags, buttons, handshake lines) through a configurable synchronizer, latches selected edges into a sticky edge-capture register, and raises a maskable interrupt. It is the next-generation replacement for the single-bit, read-only FIFO monitor port, and sits on the lightweight HPS-to-FPGA bridge next to the other PIO slaves.

## Interface
- `WIDTH`, 8, number of input bits (1..32)
- `SYNC_STAGES`, 2, synchronizer depth on `in_port` (1..4)
- `EDGE_TYPE`, 0, edge captured: 0 rising, 1 falling, 2 any
- `IRQ_MODE`, 1, 0 = level (from data), 1 = edge (from edge-capture)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `address`  in  2  word register select
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data
- `in_port`  in  WIDTH  asynchronous external inputs
- `readdata`  out  32  registered read data
- `irq`  out  1  interrupt request, active high

## Operation
- Register map (word addresses): 0 DATA (RO, synchronized input), 1 reserved (reads 0, writes ignored), 2 IRQMASK (RW), 3 EDGECAP (read; write-1-to-clear).
- Synchronizer: `SYNC_STAGES` flops per bit; `data_q` = last stage. `prev_q` holds `data_q` from the previous cycle.
- Edge detect per bit: rising `data_q & ~prev_q`, falling `~data_q & prev_q`, any `data_q ^ prev_q`.
- EDGECAP bit sets on detected edge, stays set until cleared by software.
- Write (`chipselect & ~write_n`) to 3: clear bits where `writedata[i]=1`. Edge detected on the same bit in the same cycle wins: bit stays 1.
- Write to 2: `irqmask <= writedata[WIDTH-1:0]`. Writes to 0, 1 ignored.
- `irq` = `|(data_q & irqmask)` when `IRQ_MODE`=0; `|(edgecap & irqmask)` when 1. Combinational from registers only.
- `readdata` updated every cycle from `address` mux (no read strobe qualification); upper `32-WIDTH` bits always 0.
- Reset: all sync stages, `prev_q`, `irqmask`, `edgecap`, `readdata` = 0; `irq` = 0. No spurious edge after reset release when `in_port` is 0; a high input after reset produces a rising edge once it propagates (intended).

## Timing
- Input change sampled at edge E0 -> `data_q` updates at edge E(SYNC_STAGES-1) -> EDGECAP set at E(SYNC_STAGES) -> `readdata` shows it at E(SYNC_STAGES+1).
- Read latency: 1 cycle from `address` to `readdata`.
- IRQMASK write at edge E -> `irq` reflects new mask immediately after E.
- EDGECAP clear at edge E -> `irq` drops after E unless another masked bit set or same-cycle edge.
- Reset asserted mid-operation clears state asynchronously; no pending edges survive.
- Pulses shorter than one `clk` period may be lost (documented, not a bug).

## Structure
- Shared package `soc_system_pio_pkg`: register address constants (`PIO_ADDR_DATA/MASK/EDGE`), `EDGE_TYPE` and `IRQ_MODE` encodings.
- One sub-module: `soc_system_pio_sync` (parametrised `WIDTH` x `SYNC_STAGES` synchronizer, async active-high reset). Edge logic, registers and read mux in top.

## Test plan
- Reset: hold `reset`=1 with `in_port`=8'hFF -> `readdata`=0, `irq`=0; release -> DATA reads 0xFF after SYNC_STAGES+1 cycles, EDGECAP bits all set (rising).
- Latency: `in_port` 0x00->0x05 at E0, SYNC_STAGES=2, address=3 -> EDGECAP reads 0x05 at E3, not before.
- Edge types: toggle bit 3 high then low; EDGE_TYPE 0/1/2 -> EDGECAP 0x08 after rise only / after fall only / after both.
- W1C race: EDGECAP=0x09, write 0x09 to address 3 in same cycle as new rising edge on bit 0 -> EDGECAP=0x01.
- IRQ: IRQ_MODE=1, mask 0x00, edge on bit 2 -> `irq`=0; write mask 0x04 -> `irq`=1 next cycle; clear 0x04 -> `irq`=0. IRQ_MODE=0: `irq` follows `data_q & mask`.
- Reserved/width: read address 1 -> 0; WIDTH=32 and WIDTH=1 builds, upper bits of `readdata` 0.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the soc_system PIO input-capture slave:
// register word addresses plus EDGE_TYPE / IRQ_MODE encodings.
package soc_system_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/soc_system_pio_sync.sv
// WIDTH x SYNC_STAGES flop synchronizer for asynchronous inputs.
// Ports: clk, reset (async, active high), d (raw), q (last stage).
module soc_system_pio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [SYNC_STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_capture.sv
// Avalon-MM PIO input port: synchronized DATA, IRQMASK, sticky W1C EDGECAP.
// Ports: clk, reset, address/chipselect/write_n/writedata, in_port, readdata, irq.
module soc_system_pio_in_capture
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wd;

  // Bits above WIDTH are don't-care on writes.
  assign unused_wd = ^writedata;

  soc_system_pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (in_port),
    .q    (data_q)
  );

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    edge_det = data_q & ~prev_q;
    if (EDGE_TYPE == EDGE_FALL)
      edge_det = ~data_q & prev_q;
    else if (EDGE_TYPE == EDGE_ANY)
      edge_det = data_q ^ prev_q;
  end

  always_comb begin
    clr_mask = '0;
    if (wr_en && address == PIO_ADDR_EDGE)
      clr_mask = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      PIO_ADDR_DATA: rd_mux[WIDTH-1:0] = data_q;
      PIO_ADDR_MASK: rd_mux[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecap;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q   <= '0;
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
    end else begin
      prev_q <= data_q;
      if (wr_en && address == PIO_ADDR_MASK)
        irqmask <= writedata[WIDTH-1:0];
      // A fresh edge outranks a same-cycle software clear.
      edgecap  <= (edgecap & ~clr_mask) | edge_det;
      readdata <= rd_mux;
    end
  end

  always_comb begin
    if (IRQ_MODE == IRQ_LEVEL)
      irq = |(data_q & irqmask);
    else
      irq = |(edgecap & irqmask);
  end

endmodule

// File: tb/tb_soc_system_pio_in_capture.sv
// Directed self-checking bench for soc_system_pio_in_capture.
// Five instances cover edge types, IRQ modes and WIDTH=1.
module tb_soc_system_pio_in_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in;

  logic [31:0] rd0, rd1, rd2, rd3, rd4;
  logic        irq0, irq1, irq2, irq3, irq4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  soc_system_pio_in_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)
  ) u0 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in),
    .readdata(rd0), .irq(irq0)
  );

  soc_system_pio_in_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_MODE(1)
  ) u1 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in),
    .readdata(rd1), .irq(irq1)
  );

  soc_system_pio_in_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MODE(1)
  ) u2 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in),
    .readdata(rd2), .irq(irq2)
  );

  soc_system_pio_in_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)
  ) u3 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in),
    .readdata(rd3), .irq(irq3)
  );

  soc_system_pio_in_capture #(
    .WIDTH(1), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)
  ) u4 (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in[0:0]),
    .readdata(rd4), .irq(irq4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in         = 8'hFF;

    // Reset held with inputs high
    cyc(3);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_irq0", {31'b0, irq0}, 32'h0);
    chk("rst_rd3", rd3, 32'h0);
    chk("rst_irq3", {31'b0, irq3}, 32'h0);

    // Release: DATA appears 3 edges later, not 2
    reset = 1'b0;
    cyc(2);
    chk("rel_data_early", rd0, 32'h0);
    cyc(1);
    chk("rel_data", rd0, 32'hFF);
    address = 2'd3;
    cyc(1);
    chk("rel_ecap_rise", rd0, 32'hFF);
    chk("rel_ecap_fall", rd1, 32'h00);
    chk("rel_ecap_any", rd2, 32'hFF);
    chk("rel_ecap_w1", rd4, 32'h1);

    // Clear all, inputs low, clear again
    wr(2'd3, 32'hFF);
    address = 2'd3;
    cyc(1);
    chk("w1c_all", rd0, 32'h0);
    in = 8'h00;
    cyc(4);
    wr(2'd3, 32'hFF);
    address = 2'd3;
    cyc(1);
    chk("clr_fall_any", rd2, 32'h0);

    // Latency 0x00 -> 0x05
    in = 8'h05;
    cyc(3);
    chk("lat_e2", rd0, 32'h0);
    cyc(1);
    chk("lat_e3", rd0, 32'h05);
    chk("lat_fall", rd1, 32'h00);
    chk("lat_any", rd2, 32'h05);

    // Edge types on bit 3
    wr(2'd3, 32'hFF);
    address = 2'd3;
    in = 8'h0D;
    cyc(4);
    chk("rise_et0", rd0, 32'h08);
    chk("rise_et1", rd1, 32'h00);
    chk("rise_et2", rd2, 32'h08);
    wr(2'd3, 32'hFF);
    address = 2'd3;
    in = 8'h05;
    cyc(4);
    chk("fall_et0", rd0, 32'h00);
    chk("fall_et1", rd1, 32'h08);
    chk("fall_et2", rd2, 32'h08);

    // W1C vs same-cycle rising edge on bit 0
    wr(2'd3, 32'hFF);
    in = 8'h04;
    cyc(4);
    in = 8'h0D;
    cyc(4);
    in = 8'h04;
    cyc(4);
    address = 2'd3;
    cyc(1);
    chk("race_pre", rd0, 32'h09);
    in = 8'h05;
    cyc(2);
    wr(2'd3, 32'h09);
    cyc(1);
    chk("race_post", rd0, 32'h01);

    // IRQ edge mode, bit 2
    wr(2'd3, 32'hFF);
    in = 8'h01;
    cyc(4);
    in = 8'h05;
    cyc(4);
    chk("irq_unmasked", {31'b0, irq0}, 32'h0);
    wr(2'd2, 32'h04);
    chk("irq_masked", {31'b0, irq0}, 32'h1);
    chk("irq_lvl_hi", {31'b0, irq3}, 32'h1);
    wr(2'd3, 32'h04);
    chk("irq_cleared", {31'b0, irq0}, 32'h0);
    in = 8'h01;
    cyc(3);
    chk("irq_lvl_lo", {31'b0, irq3}, 32'h0);

    // Reserved address and width
    wr(2'd1, 32'hFFFFFFFF);
    address = 2'd1;
    cyc(1);
    chk("rsvd_read", rd0, 32'h0);
    address = 2'd2;
    cyc(1);
    chk("rsvd_nowrite", rd0, 32'h04);
    wr(2'd2, 32'hFFFFFFFF);
    address = 2'd2;
    cyc(1);
    chk("mask_width8", rd0, 32'hFF);
    chk("mask_width1", rd4, 32'h1);
    address = 2'd0;
    cyc(1);
    chk("data_width1", rd4, 32'h1);
    chk("data_width8", rd0, 32'h01);

    // Async reset mid-operation
    in = 8'h00;
    cyc(4);
    in = 8'h03;
    cyc(4);
    chk("pre_rst_irq", {31'b0, irq0}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_irq", {31'b0, irq0}, 32'h0);
    chk("async_rd", rd0, 32'h0);
    in = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    address = 2'd3;
    cyc(4);
    chk("post_rst_ecap", rd0, 32'h0);
    chk("post_rst_irq", {31'b0, irq0}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
